// File: rtl/trigger_activity_monitor.sv
// Gated rising-edge rate counter with snapshot read port and activity flags.
// Optional TRIG_ACTIVITY_SATURATE_EN: live counters saturate instead of wrapping.
module trigger_activity_monitor #(
  parameter int NUM_CHANNELS = 12,
  parameter int GATE_CYCLES  = 250000000,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] trig_in,
  input  logic                    rd_en,
  input  logic [3:0]              rd_channel,
  output logic                    rd_valid,
  output logic [COUNT_WIDTH-1:0]  rd_data,
  output logic                    gate_done,
  output logic [NUM_CHANNELS-1:0] activity
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0] GATE_ONE = GW'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  (* ASYNC_REG = "TRUE" *) logic [NUM_CHANNELS-1:0] sync1;
  (* ASYNC_REG = "TRUE" *) logic [NUM_CHANNELS-1:0] sync2;
  logic [NUM_CHANNELS-1:0] sync3;
  logic [NUM_CHANNELS-1:0] rise;
  logic [NUM_CHANNELS-1:0] act_next;

  logic [GW-1:0] gate;
  logic          terminal;

  logic [COUNT_WIDTH-1:0] live     [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0] snap     [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0] inc_live [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0] rd_mux;

  assign rise     = sync2 & ~sync3;
  assign terminal = (gate == GATE_LAST);

  // inc_live doubles as the closing value on the terminal cycle
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
`ifdef TRIG_ACTIVITY_SATURATE_EN
      if (rise[i] && (live[i] != CNT_MAX))
        inc_live[i] = live[i] + CNT_ONE;
      else
        inc_live[i] = live[i];
`else
      if (rise[i])
        inc_live[i] = live[i] + CNT_ONE;
      else
        inc_live[i] = live[i];
`endif
      act_next[i] = (inc_live[i] != '0);
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (rd_channel == 4'(i))
        rd_mux = snap[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      sync3     <= '0;
      gate      <= '0;
      gate_done <= 1'b0;
      activity  <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        live[i] <= '0;
        snap[i] <= '0;
      end
    end else begin
      sync1     <= trig_in;
      sync2     <= sync1;
      sync3     <= sync2;
      gate      <= terminal ? '0 : gate + GATE_ONE;
      gate_done <= terminal;
      rd_valid  <= rd_en;
      if (rd_en)
        rd_data <= rd_mux;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        live[i] <= terminal ? '0 : inc_live[i];
        if (terminal)
          snap[i] <= inc_live[i];
      end
      if (terminal)
        activity <= act_next;
    end
  end

endmodule
